// File: rtl/uart_pkg.sv
// Shared definitions for the UART packet controller: state encoding,
// default sync marker and the 8-bit wrap-around checksum helper.
package uart_pkg;

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        HOLD = 3'd4
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/uart_pkt_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled and flags expiry
// when TIMEOUT_CYC cycles pass without a clear (byte tick).
module uart_pkt_timeout #(
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    // Saturates at LAST; the controller leaves the timed states on expiry.
    always_ff @(posedge clk) begin
        if (reset || clear || !enable) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign expire = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer on top of the UART byte receiver: SYNC, LEN, payload and,
// when UART_PKT_CHECKSUM_EN is defined, a trailing zero-sum checksum byte.
module uart_rx_pkt_ctrl
    import uart_pkg::*;
#(
    parameter int         DBIT        = 8,
    parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 20000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx_done_tick,
    input  logic [DBIT-1:0]            rx_dout,
    output logic                       pkt_valid,
    input  logic                       pkt_ready,
    output logic [7:0]                 pkt_len,
    input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
    output logic [DBIT-1:0]            rd_data,
    output logic                       err_len,
    output logic                       err_timeout,
    output logic                       err_csum,
    output logic                       overrun
);

    localparam int         AW       = $clog2(MAX_LEN);
    localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

    state_t          state, state_nx;
    logic [7:0]      len_q, len_nx;
    logic [7:0]      idx_q, idx_nx;
    logic [7:0]      rx_byte;
    logic            wr_en;
    logic            tmo_en, expire;
    logic            err_len_nx, err_timeout_nx, err_csum_nx, overrun_nx;
    logic [DBIT-1:0] buf_mem [MAX_LEN];
`ifdef UART_PKT_CHECKSUM_EN
    logic [7:0]      sum_q, sum_nx;
`endif

    assign rx_byte = 8'(rx_dout);
    assign tmo_en  = (state == LEN) || (state == DATA) || (state == CSUM);

    uart_pkt_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .enable (tmo_en),
        .clear  (rx_done_tick),
        .expire (expire)
    );

    always_comb begin
        state_nx       = state;
        len_nx         = len_q;
        idx_nx         = idx_q;
        wr_en          = 1'b0;
        err_len_nx     = 1'b0;
        err_timeout_nx = 1'b0;
        err_csum_nx    = 1'b0;
        overrun_nx     = 1'b0;
`ifdef UART_PKT_CHECKSUM_EN
        sum_nx         = sum_q;
`endif
        if (expire) begin
            err_timeout_nx = 1'b1;
            state_nx       = HUNT;
        end else begin
            case (state)
                HUNT: if (rx_done_tick && rx_byte == SYNC_BYTE) state_nx = LEN;
                LEN: if (rx_done_tick) begin
                    if (rx_byte != 8'd0 && rx_byte <= MAX_LEN8) begin
                        len_nx   = rx_byte;
                        idx_nx   = 8'd0;
                        state_nx = DATA;
`ifdef UART_PKT_CHECKSUM_EN
                        sum_nx   = rx_byte;
`endif
                    end else begin
                        err_len_nx = 1'b1;
                        state_nx   = HUNT;
                    end
                end
                DATA: if (rx_done_tick) begin
                    wr_en = 1'b1;
`ifdef UART_PKT_CHECKSUM_EN
                    sum_nx = sum8(sum_q, rx_byte);
                    if (idx_q == len_q - 8'd1) state_nx = CSUM;
`else
                    if (idx_q == len_q - 8'd1) state_nx = HOLD;
`endif
                    else idx_nx = idx_q + 8'd1;
                end
`ifdef UART_PKT_CHECKSUM_EN
                CSUM: if (rx_done_tick) begin
                    if (sum8(sum_q, rx_byte) == 8'd0) begin
                        state_nx = HOLD;
                    end else begin
                        err_csum_nx = 1'b1;
                        state_nx    = HUNT;
                    end
                end
`endif
                HOLD: begin
                    // Bytes are dropped even on the handshake cycle.
                    overrun_nx = rx_done_tick;
                    if (pkt_ready) state_nx = HUNT;
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            len_q       <= 8'd0;
            idx_q       <= 8'd0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_csum    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nx;
            len_q       <= len_nx;
            idx_q       <= idx_nx;
            err_len     <= err_len_nx;
            err_timeout <= err_timeout_nx;
            err_csum    <= err_csum_nx;
            overrun     <= overrun_nx;
        end
    end

`ifdef UART_PKT_CHECKSUM_EN
    always_ff @(posedge clk) sum_q <= sum_nx;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) buf_mem[idx_q[AW-1:0]] <= rx_dout;
    end

    assign pkt_valid = (state == HOLD);
    assign pkt_len   = len_q;
    assign rd_data   = buf_mem[rd_addr];

endmodule
